float_convert_pipe: RTL and testbench
=====================================

# float_convert_pipe

Pipelined, parametrised FP32↔FP16 format converter for the FPU.
- Accepts one conversion per cycle over a valid/ready handshake.
- Applies a run-time rounding mode and raises IEEE exception flags.
- Carries a caller tag so results can be matched to their requests.
- Sits between the FPU issue stage and the result writeback arbiter.
- Single-precision results are 32-bit; half-precision results are NaN-boxed into 32 bits.

## Interface
Parameters:
- STAGES, 2: pipeline depth in registers. Legal range 1–4. Latency from accept to result equals STAGES.
- TAG_W, 4: width of the pass-through tag.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset. Synchronous and active-high: sampled on the CLK rising edge, high = reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_data  in  32  operand. A half operand occupies [15:0].
- in_cvt  in  fpu_fmt_cvt_t  conversion direction: CVT_S2H or CVT_H2S.
- in_rm  in  3  rounding mode: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100. Codes 101–111 behave as RNE.
- in_tag  in  TAG_W  opaque request tag.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  32  result.
- out_flags  out  5  {NV,DZ,OF,UF,NX}.
- out_tag  out  TAG_W  tag of this result.

## Operation
- S2H (rebias exponent e-127+15, round 23→10 fraction bits per in_rm):
  - Zero → signed half zero. Inf → signed half inf.
  - NaN → canonical 16'h7E00. Raise NV if the input is signalling (fraction MSB 0).
  - Overflow after rounding: raise OF|NX.
    - RNE and RMM → ±inf.
    - RTZ → ±16'h7BFF.
    - RDN → +max finite for positive, -inf for negative.
    - RUP → +inf for positive, -max finite for negative.
  - Tiny result: denormalise to a half subnormal, then round. Raise UF only when the result is both tiny and inexact. A zero result keeps its sign.
  - Any rounding loss raises NX.
  - Result is {16'hFFFF, half}.
- H2S (always exact, NX/OF/UF never raised):
  - If in_data[31:16] != 16'hFFFF, the operand is not NaN-boxed: treat it as canonical NaN, return 32'h7FC00000, no flags.
  - Half subnormals are normalised.
  - NaN → 32'h7FC00000, with NV if signalling.
- DZ is always 0.
- in_rm is ignored for H2S.

## Timing
- Pipeline advances on a global enable: adv = !out_valid || out_ready.
  - in_ready = adv. It is combinational, the only output not driven by a register.
  - Invalid slots advance as bubbles; bubbles are not collapsed.
- Throughput 1/cycle while out_ready is high. Latency is exactly STAGES cycles after acceptance if never stalled.
- When out_ready is low with out_valid high:
  - every stage holds;
  - out_data, out_flags and out_tag stay stable;
  - in_ready is low.
- Results leave in acceptance order. No drop, no duplication.
- in_valid while in_ready is low: the request is not captured; the requester must hold it.
- Reset values on the cycle after RST high:
  - all stage valid bits 0, so out_valid = 0;
  - out_data = 32'h0, out_flags = 5'h0, out_tag = 0.
- Reset mid-operation discards every in-flight request. No result is produced for them.
- RST high has priority over a simultaneous handshake. An input presented in the reset cycle is dropped.
- Stage split:
  - STAGES=1: single output register.
  - STAGES=2: unpack/normalise | round/pack.
  - STAGES≥3: additional registers placed after the round stage.

## Structure
- In fpu_types_pkg:
  - typedef enum fpu_fmt_cvt_t {CVT_S2H, CVT_H2S};
  - typedef enum for rounding mode, fpu_rm_t;
  - constants CANON_NAN_H = 16'h7E00, CANON_NAN_S = 32'h7FC00000, HALF_MAX = 16'h7BFF, NAN_BOX = 16'hFFFF;
  - flag bit index constants.
- Sub-module fcvt_hs_core:
  - purely combinational, split into unpack and round halves at a clean boundary;
  - the pipeline wrapper instantiates it and inserts registers per STAGES.
- The wrapper owns valid bits, tag shift, stall logic and reset.

## Test plan
- S2H 32'h3F800000, RNE → after STAGES cycles out_data 32'hFFFF3C00, flags 0, tag echoed.
- S2H 32'h477FF000 (65520):
  - RNE → 32'hFFFF7C00, flags OF|NX (5'b00101);
  - RTZ → 32'hFFFF7BFF, same flags.
- S2H subnormal and underflow:
  - 32'h33800000 → 32'hFFFF0001, flags 0;
  - 32'h33000000 RNE → 32'hFFFF0000, flags UF|NX;
  - 32'h7F800001 → 32'hFFFF7E00, NV.
- H2S:
  - 32'hFFFF0001 → 32'h33800000, flags 0;
  - 32'hFFFF7D00 → 32'h7FC00000, NV;
  - 32'h00003C00 (not boxed) → 32'h7FC00000, flags 0.
- Backpressure: issue tags 1,2,3 back-to-back and hold out_ready low 5 cycles → in_ready low; outputs stable; after release, tags emerge 1,2,3, once each.
- Reset mid-flight: assert RST with 2 ops in flight → out_valid 0 next cycle and all outputs 0; the in-flight results never appear; a new op after reset completes in STAGES cycles.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared FPU types: conversion direction, rounding modes, special constants,
// flag bit positions and the record passed between the converter halves.
package fpu_types_pkg;

  typedef enum logic {
    CVT_S2H = 1'b0,
    CVT_H2S = 1'b1
  } fpu_fmt_cvt_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } fpu_rm_t;

  localparam logic [15:0] CANON_NAN_H = 16'h7E00;
  localparam logic [31:0] CANON_NAN_S = 32'h7FC00000;
  localparam logic [15:0] HALF_MAX    = 16'h7BFF;
  localparam logic [15:0] NAN_BOX     = 16'hFFFF;

  // Flag vector is {NV,DZ,OF,UF,NX}
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Unpack -> round boundary. When special is set the result is already
  // final; otherwise exp/man/guard/sticky describe a half value to round.
  typedef struct packed {
    logic        special;
    logic [31:0] spec_data;
    logic [4:0]  spec_flags;
    logic        sign;
    fpu_rm_t     rm;
    logic        big;     // exponent beyond half range before rounding
    logic        tiny;    // denormalised into the half subnormal range
    logic [4:0]  exp;     // half exponent field (0 when tiny)
    logic [10:0] man;     // kept significand incl. hidden bit
    logic        guard;
    logic        sticky;
  } cvt_mid_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
  } cvt_res_t;

  // Reserved rounding codes fall back to round-to-nearest-even.
  function automatic fpu_rm_t rm_decode(input logic [2:0] rm);
    return (rm > 3'd4) ? RM_RNE : fpu_rm_t'(rm);
  endfunction

endpackage

// File: rtl/fcvt_hs_core.sv
// Combinational FP32<->FP16 converter, split into an unpack/normalise half
// (in_* -> mid_o) and a round/pack half (mid_i -> res). The wrapper decides
// whether a register sits between the two.
module fcvt_hs_core
  import fpu_types_pkg::*;
(
  input  logic [31:0]  in_data,
  input  fpu_fmt_cvt_t in_cvt,
  input  logic [2:0]   in_rm,
  output cvt_mid_t     mid_o,
  input  cvt_mid_t     mid_i,
  output cvt_res_t     res
);

  logic [7:0]        se;
  logic [22:0]       sf;
  logic [23:0]       sig;
  logic signed [9:0] hexp;
  logic signed [9:0] dsh;
  logic [9:0]        shamt;
  logic [49:0]       wide;
  logic [4:0]        he5;
  logic [9:0]        hf;
  logic [3:0]        lead;
  logic [10:0]       hnorm;

  // Unpack: classify specials, rebias, denormalise into 11 kept bits + G/S
  always_comb begin
    mid_o = '0;
    se    = in_data[30:23];
    sf    = in_data[22:0];
    sig   = {(se != 8'd0), sf};
    hexp  = $signed({2'b00, ((se == 8'd0) ? 8'd1 : se)}) - 10'sd112;
    dsh   = 10'sd1 - hexp;
    shamt = 10'd0;
    he5   = in_data[14:10];
    hf    = in_data[9:0];
    lead  = 4'd0;
    for (int i = 0; i < 10; i++)
      if (hf[i]) lead = i[3:0];
    hnorm = {1'b0, hf} << (4'd10 - lead);

    if (in_cvt == CVT_H2S) begin
      // Widening is exact, so everything resolves here.
      mid_o.special = 1'b1;
      if (in_data[31:16] != NAN_BOX)
        mid_o.spec_data = CANON_NAN_S;
      else if (he5 == 5'h1F) begin
        if (hf == 10'd0) mid_o.spec_data = {in_data[15], 8'hFF, 23'd0};
        else begin
          mid_o.spec_data          = CANON_NAN_S;
          mid_o.spec_flags[FLG_NV] = ~hf[9];
        end
      end else if (he5 == 5'd0) begin
        if (hf == 10'd0) mid_o.spec_data = {in_data[15], 31'd0};
        else mid_o.spec_data = {in_data[15], 8'd103 + {4'd0, lead}, hnorm[9:0], 13'd0};
      end else
        mid_o.spec_data = {in_data[15], {3'd0, he5} + 8'd112, hf, 13'd0};
    end else begin
      mid_o.sign = in_data[31];
      mid_o.rm   = rm_decode(in_rm);
      if (se == 8'hFF) begin
        mid_o.special = 1'b1;
        if (sf != 23'd0) begin
          mid_o.spec_data          = {NAN_BOX, CANON_NAN_H};
          mid_o.spec_flags[FLG_NV] = ~sf[22];
        end else
          mid_o.spec_data = {NAN_BOX, in_data[31], 5'h1F, 10'd0};
      end else if (se == 8'd0 && sf == 23'd0) begin
        mid_o.special   = 1'b1;
        mid_o.spec_data = {NAN_BOX, in_data[31], 15'd0};
      end else begin
        if (hexp >= 10'sd31)
          mid_o.big = 1'b1;
        else if (hexp <= 10'sd0) begin
          mid_o.tiny = 1'b1;
          // Beyond 26 places every bit is sticky anyway.
          shamt = (dsh > 10'sd26) ? 10'd26 : dsh;
        end else
          mid_o.exp = hexp[4:0];
      end
    end

    wide         = {sig, 26'd0} >> shamt;
    mid_o.man    = mid_o.big ? 11'd0 : wide[49:39];
    mid_o.guard  = wide[38];
    mid_o.sticky = |wide[37:0];
  end

  logic        inexact;
  logic        inc;
  logic        ovf;
  logic [14:0] sum;
  logic [15:0] half;

  // Round/pack: apply the rounding increment and resolve overflow by mode
  always_comb begin
    res     = '0;
    half    = '0;
    inexact = mid_i.guard | mid_i.sticky;
    case (mid_i.rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = mid_i.sign & inexact;
      RM_RUP:  inc = ~mid_i.sign & inexact;
      RM_RMM:  inc = mid_i.guard;
      default: inc = mid_i.guard & (mid_i.sticky | mid_i.man[0]);
    endcase
    // Carry out of the fraction walks into the exponent field, which also
    // promotes a rounded-up subnormal to the minimum normal.
    sum = {mid_i.exp, mid_i.man[9:0]} + {14'd0, inc};
    // Overflow once the magnitude reaches the nearest-rounding threshold
    // (65520) in any mode, or when the increment itself reaches infinity.
    ovf = mid_i.big
        | ((mid_i.exp == 5'd30) && (mid_i.man == 11'h7FF) && mid_i.guard)
        | (sum[14:10] == 5'h1F);

    if (mid_i.special) begin
      res.data  = mid_i.spec_data;
      res.flags = mid_i.spec_flags;
    end else begin
      if (ovf) begin
        res.flags[FLG_OF] = 1'b1;
        res.flags[FLG_NX] = 1'b1;
        case (mid_i.rm)
          RM_RTZ:  half = {mid_i.sign, HALF_MAX[14:0]};
          RM_RDN:  half = mid_i.sign ? 16'hFC00 : HALF_MAX;
          RM_RUP:  half = mid_i.sign ? {1'b1, HALF_MAX[14:0]} : 16'h7C00;
          default: half = {mid_i.sign, 15'h7C00};
        endcase
      end else begin
        half              = {mid_i.sign, sum};
        res.flags[FLG_NX] = inexact;
        res.flags[FLG_UF] = mid_i.tiny & inexact;
      end
      res.data = {NAN_BOX, half};
    end
  end

endmodule

// File: rtl/float_convert_pipe.sv
// Pipelined FP32<->FP16 converter with valid/ready handshake. One global
// advance enable moves every stage together; bubbles are not collapsed.
module float_convert_pipe
  import fpu_types_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  fpu_fmt_cvt_t     in_cvt,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  // First register holding a rounded result: after the unpack register
  // when there are at least two stages.
  localparam int RF = (STAGES == 1) ? 1 : 2;

  logic                        adv;
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][TAG_W-1:0]  tag_pipe;
  cvt_res_t                    res_pipe [STAGES:RF];
  cvt_mid_t                    mid_d, mid_r;
  cvt_res_t                    res_d;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  fcvt_hs_core u_core (
    .in_data (in_data),
    .in_cvt  (in_cvt),
    .in_rm   (in_rm),
    .mid_o   (mid_d),
    .mid_i   (mid_r),
    .res     (res_d)
  );

  generate
    if (STAGES == 1) begin : g_no_mid
      assign mid_r = mid_d;
    end else begin : g_mid
      cvt_mid_t mid_q;
      // Unpack/normalise register
      always_ff @(posedge CLK) begin
        if (RST)      mid_q <= '0;
        else if (adv) mid_q <= mid_d;
      end
      assign mid_r = mid_q;
    end
  endgenerate

  // Valid and tag shift registers; reset discards everything in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      tag_pipe[1] <= in_tag;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Rounded result register plus any trailing delay registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = RF; i <= STAGES; i++) res_pipe[i] <= '0;
    end else if (adv) begin
      res_pipe[RF] <= res_d;
      for (int i = RF + 1; i <= STAGES; i++) res_pipe[i] <= res_pipe[i-1];
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_tag   = tag_pipe[STAGES];
  assign out_data  = res_pipe[STAGES].data;
  assign out_flags = res_pipe[STAGES].flags;

endmodule

// File: tb/tb_float_convert_pipe.sv
// Directed bench for float_convert_pipe: vector table plus backpressure and
// mid-flight reset sequences.
module tb_float_convert_pipe;
  import fpu_types_pkg::*;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  fpu_fmt_cvt_t     in_cvt = CVT_S2H;
  logic [2:0]       in_rm = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  float_convert_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cvt    (in_cvt),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [TAG_W-1:0] tq [$];
  logic [31:0]      dq [$];

  // Record every consumed result
  always @(posedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      tq.push_back(out_tag);
      dq.push_back(out_data);
    end
  end

  typedef struct packed {
    logic [31:0]  d;
    fpu_fmt_cvt_t cvt;
    logic [2:0]   rm;
    logic [3:0]   tag;
    logic [31:0]  xd;
    logic [4:0]   xf;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Single op with out_ready high: measure latency and check the result
  task automatic apply(input vec_t v, input int idx);
    int lat;
    @(negedge CLK);
    in_valid = 1'b1; in_data = v.d; in_cvt = v.cvt; in_rm = v.rm; in_tag = v.tag;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(STAGES));
    check($sformatf("v%0d_data", idx), out_data, v.xd);
    check($sformatf("v%0d_flags", idx), {27'd0, out_flags}, {27'd0, v.xf});
    check($sformatf("v%0d_tag", idx), {28'd0, out_tag}, {28'd0, v.tag});
  endtask

  // Present a request and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input fpu_fmt_cvt_t c, input logic [3:0] t);
    int n;
    @(negedge CLK);
    in_valid = 1'b1; in_data = d; in_cvt = c; in_rm = 3'd0; in_tag = t;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: tag %0d never accepted, expected acceptance", t);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    vecs.push_back({32'h3F800000, CVT_S2H, 3'd0, 4'd1,  32'hFFFF3C00, 5'h00});
    vecs.push_back({32'h477FF000, CVT_S2H, 3'd0, 4'd2,  32'hFFFF7C00, 5'h05});
    vecs.push_back({32'h477FF000, CVT_S2H, 3'd1, 4'd3,  32'hFFFF7BFF, 5'h05});
    vecs.push_back({32'hC77FF000, CVT_S2H, 3'd2, 4'd4,  32'hFFFFFC00, 5'h05});
    vecs.push_back({32'hC77FF000, CVT_S2H, 3'd3, 4'd5,  32'hFFFFFBFF, 5'h05});
    vecs.push_back({32'h477FF000, CVT_S2H, 3'd2, 4'd6,  32'hFFFF7BFF, 5'h05});
    vecs.push_back({32'h33800000, CVT_S2H, 3'd0, 4'd7,  32'hFFFF0001, 5'h00});
    vecs.push_back({32'h33000000, CVT_S2H, 3'd0, 4'd8,  32'hFFFF0000, 5'h03});
    vecs.push_back({32'hB3000000, CVT_S2H, 3'd2, 4'd9,  32'hFFFF8001, 5'h03});
    vecs.push_back({32'h7F800001, CVT_S2H, 3'd0, 4'd10, 32'hFFFF7E00, 5'h10});
    vecs.push_back({32'h7FC00000, CVT_S2H, 3'd0, 4'd11, 32'hFFFF7E00, 5'h00});
    vecs.push_back({32'hFF800000, CVT_S2H, 3'd0, 4'd12, 32'hFFFFFC00, 5'h00});
    vecs.push_back({32'h80000000, CVT_S2H, 3'd0, 4'd13, 32'hFFFF8000, 5'h00});
    vecs.push_back({32'h3F801000, CVT_S2H, 3'd0, 4'd14, 32'hFFFF3C00, 5'h01});
    vecs.push_back({32'h3F801000, CVT_S2H, 3'd3, 4'd15, 32'hFFFF3C01, 5'h01});
    vecs.push_back({32'h3F801000, CVT_S2H, 3'd4, 4'd0,  32'hFFFF3C01, 5'h01});
    vecs.push_back({32'h3F803000, CVT_S2H, 3'd7, 4'd1,  32'hFFFF3C02, 5'h01});
    vecs.push_back({32'hFFFF0001, CVT_H2S, 3'd0, 4'd2,  32'h33800000, 5'h00});
    vecs.push_back({32'hFFFF7D00, CVT_H2S, 3'd0, 4'd3,  32'h7FC00000, 5'h10});
    vecs.push_back({32'h00003C00, CVT_H2S, 3'd0, 4'd4,  32'h7FC00000, 5'h00});
    vecs.push_back({32'hFFFF3C00, CVT_H2S, 3'd5, 4'd5,  32'h3F800000, 5'h00});
    vecs.push_back({32'hFFFFFC00, CVT_H2S, 3'd0, 4'd6,  32'hFF800000, 5'h00});

    // Reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_flags", {27'd0, out_flags}, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    repeat (3) @(posedge CLK);
    #1;
    check("vec_result_count", tq.size(), vecs.size());
    for (int i = 0; i < vecs.size() && i < tq.size(); i++)
      check($sformatf("vec_order_%0d", i), {28'd0, tq[i]}, {28'd0, vecs[i].tag});

    // Backpressure: tags 1,2,3 with out_ready low
    tq.delete(); dq.delete();
    out_ready = 1'b0;
    send(32'hFFFF3C00, CVT_H2S, 4'd1);
    send(32'hFFFF4000, CVT_H2S, 4'd2);
    @(negedge CLK);
    in_valid = 1'b1; in_data = 32'hFFFF4200; in_cvt = CVT_H2S; in_rm = 3'd0; in_tag = 4'd3;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d_out_tag", i), {28'd0, out_tag}, 32'd1);
      check($sformatf("stall%0d_out_data", i), out_data, 32'h3F800000);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("bp_count", tq.size(), 32'd3);
    if (tq.size() == 3) begin
      check("bp_tag0", {28'd0, tq[0]}, 32'd1);
      check("bp_tag1", {28'd0, tq[1]}, 32'd2);
      check("bp_tag2", {28'd0, tq[2]}, 32'd3);
      check("bp_data0", dq[0], 32'h3F800000);
      check("bp_data1", dq[1], 32'h40000000);
      check("bp_data2", dq[2], 32'h40400000);
    end

    // Reset with two ops in flight plus an op offered in the reset cycle
    tq.delete(); dq.delete();
    out_ready = 1'b0;
    send(32'h3F800000, CVT_S2H, 4'd5);
    send(32'h3F800000, CVT_S2H, 4'd6);
    @(negedge CLK);
    RST = 1'b1;
    in_valid = 1'b1; in_data = 32'h3F800000; in_cvt = CVT_S2H; in_tag = 4'd7;
    @(posedge CLK); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_flags", {27'd0, out_flags}, 32'd0);
    check("midrst_out_tag", {28'd0, out_tag}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    check("midrst_no_ghosts", tq.size(), 32'd0);
    apply({32'h3F800000, CVT_S2H, 3'd0, 4'd8, 32'hFFFF3C00, 5'h00}, 99);
    repeat (2) @(posedge CLK);
    #1;
    check("post_rst_count", tq.size(), 32'd1);
    if (tq.size() == 1) check("post_rst_tag", {28'd0, tq[0]}, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
